// File: rtl/ram_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_bist_pkg                                                 |
// | Description : Shared constants for the March BIST controller. Holds the    |
// |               FSM state encoding, the March element count and the number   |
// |               of RAM accesses one full test takes.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram_bist_pkg;

  localparam int unsigned c_STATE_W = 3;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_IDLE = 3'd0;
  localparam state_t c_ST_M0_W = 3'd1;
  localparam state_t c_ST_M1_R = 3'd2;
  localparam state_t c_ST_M1_W = 3'd3;
  localparam state_t c_ST_M2_R = 3'd4;
  localparam state_t c_ST_M2_W = 3'd5;
  localparam state_t c_ST_M3_R = 3'd6;
  localparam state_t c_ST_DONE = 3'd7;

  // W0 up; R0W1 up; R1W0 down; R0 up
  localparam int unsigned c_NUM_ELEMENTS      = 4;
  // One write in M0, read+write in M1 and M2, one read in M3
  localparam int unsigned c_ACCESSES_PER_ADDR = 6;

  function automatic int unsigned cycles_per_test(input int unsigned depth);
    return c_ACCESSES_PER_ADDR * depth;
  endfunction

  localparam int unsigned c_DEFAULT_DEPTH           = 16;
  localparam int unsigned c_DEFAULT_CYCLES_PER_TEST = cycles_per_test(c_DEFAULT_DEPTH);

endpackage
`default_nettype wire

// File: rtl/ram_march_bist_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_march_bist_if                                            |
// | Description : RAM-side bus between the BIST controller (master) and a      |
// |               single-port asynchronous-read RAM (slave).                   |
// |   ram_address  : word address                                              |
// |   ram_data_in  : write data                                                |
// |   ram_write_en : write strobe, active high                                 |
// |   ram_data_out : combinational read data                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ram_march_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_write_en;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport master (
    output ram_address,
    output ram_data_in,
    output ram_write_en,
    input  ram_data_out
  );

  modport slave (
    input  ram_address,
    input  ram_data_in,
    input  ram_write_en,
    output ram_data_out
  );

endinterface
`default_nettype wire

// File: rtl/ram_bist_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_bist_addr_gen                                            |
// | Description : Up/down address counter for the March sequencer.             |
// |   clk, rst_n : clock, synchronous active-low reset (counter -> 0)          |
// |   i_clear    : load 0 (start of an ascending element)                      |
// |   i_load     : load all-ones (start of a descending element)               |
// |   i_dir      : 0 = ascending, 1 = descending                               |
// |   i_step     : advance one address in direction i_dir                      |
// |   o_addr     : current address                                             |
// |   o_last     : terminal address for i_dir (max going up, 0 going down)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_clear,
  input  wire logic                  i_load,
  input  wire logic                  i_dir,
  input  wire logic                  i_step,
  output logic      [ADDR_WIDTH-1:0] o_addr,
  output logic                       o_last
);

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] r_addr;

  // The sequencer never steps on the terminal address, so no wrap occurs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= c_ADDR_MAX;
    end else if (i_step) begin
      r_addr <= i_dir ? (r_addr - 1'b1) : (r_addr + 1'b1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_dir ? (r_addr == '0) : (r_addr == c_ADDR_MAX);

endmodule
`default_nettype wire

// File: rtl/ram_sp_asyn_read.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_sp_asyn_read                                             |
// | Description : Single-port RAM, synchronous write, asynchronous read.       |
// |   clk          : write clock                                               |
// |   i_address    : word address (shared by read and write)                   |
// |   i_data_in    : write data                                                |
// |   i_write_en   : write strobe, active high                                 |
// |   o_data_out   : combinational read of the addressed word                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_sp_asyn_read #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic                  clk,
  input  wire logic [ADDR_WIDTH-1:0] i_address,
  input  wire logic [DATA_WIDTH-1:0] i_data_in,
  input  wire logic                  i_write_en,
  output logic      [DATA_WIDTH-1:0] o_data_out
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  // Storage has no reset: contents are only meaningful once written
  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_write_en) begin
      r_mem[i_address] <= i_data_in;
    end
  end

  assign o_data_out = r_mem[i_address];

endmodule
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_march_bist                                               |
// | Description : March BIST controller (W0 up; R0W1 up; R1W0 down; R0 up)     |
// |               for a single-port asynchronous-read RAM.                     |
// |   clk, rst_n   : clock, synchronous active-low reset                       |
// |   i_start      : level start request, accepted only in IDLE                |
// |   i_pattern    : background word P, latched on accepted start             |
// |   o_busy       : a March element is executing                              |
// |   o_done       : one-cycle completion pulse                                |
// |   o_pass       : 1 = no mismatches; valid from o_done to next start        |
// |   o_fail_count : saturating mismatch count                                 |
// |   o_fail_addr  : address of first mismatch, 0 if none                      |
// |   ram_bus      : RAM address/data/write-enable out, read data in           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 7
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_start,
  input  wire logic [DATA_WIDTH-1:0] i_pattern,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_pass,
  output logic      [CNT_WIDTH-1:0]  o_fail_count,
  output logic      [ADDR_WIDTH-1:0] o_fail_addr,
  ram_march_bist_if.master           ram_bus
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_go;
  logic [DATA_WIDTH-1:0] r_pattern;
  logic [CNT_WIDTH-1:0]  r_fail_count;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic                  r_pass;

  logic                  w_start_accept;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_last;
  logic                  w_ag_clear;
  logic                  w_ag_load;
  logic                  w_ag_dir;
  logic                  w_ag_step;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_write;
  logic                  w_read;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_expected;
  logic                  w_mismatch;

  // Accepting start spends one cycle in IDLE (r_go) so M0_W begins on the
  // edge after acceptance; r_go also blocks a second acceptance meanwhile.
  assign w_start_accept = (r_state == c_ST_IDLE) && i_start && !r_go;

  //--------------------------------------------------------------------------
  // Address counter
  //--------------------------------------------------------------------------
  always_comb begin
    w_ag_clear = 1'b0;
    w_ag_load  = 1'b0;
    w_ag_step  = 1'b0;
    w_ag_dir   = (r_state == c_ST_M2_R) || (r_state == c_ST_M2_W);
    case (r_state)
      c_ST_IDLE: w_ag_clear = w_start_accept;
      c_ST_M0_W: begin
        w_ag_clear = w_last;
        w_ag_step  = !w_last;
      end
      c_ST_M1_W: begin
        w_ag_load  = w_last;      // M2 starts at the top address
        w_ag_step  = !w_last;
      end
      c_ST_M2_W: begin
        w_ag_clear = w_last;
        w_ag_step  = !w_last;
      end
      c_ST_M3_R: w_ag_step = !w_last;
      default: ;
    endcase
  end

  ram_bist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_ag_clear),
    .i_load  (w_ag_load),
    .i_dir   (w_ag_dir),
    .i_step  (w_ag_step),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_go    <= w_start_accept;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (r_go)   w_next_state = c_ST_M0_W;
      c_ST_M0_W: if (w_last) w_next_state = c_ST_M1_R;
      c_ST_M1_R:             w_next_state = c_ST_M1_W;
      c_ST_M1_W:             w_next_state = w_last ? c_ST_M2_R : c_ST_M1_R;
      c_ST_M2_R:             w_next_state = c_ST_M2_W;
      c_ST_M2_W:             w_next_state = w_last ? c_ST_M3_R : c_ST_M2_R;
      c_ST_M3_R: if (w_last) w_next_state = c_ST_DONE;
      c_ST_DONE:             w_next_state = c_ST_IDLE;
      default:               w_next_state = c_ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_write    = 1'b0;
    w_read     = 1'b0;
    w_wdata    = '0;
    w_expected = r_pattern;
    case (r_state)
      c_ST_M0_W: begin
        w_busy  = 1'b1;
        w_write = 1'b1;
        w_wdata = r_pattern;
      end
      c_ST_M1_R: begin
        w_busy     = 1'b1;
        w_read     = 1'b1;
        w_expected = r_pattern;
        w_wdata    = r_pattern;
      end
      c_ST_M1_W: begin
        w_busy  = 1'b1;
        w_write = 1'b1;
        w_wdata = ~r_pattern;
      end
      c_ST_M2_R: begin
        w_busy     = 1'b1;
        w_read     = 1'b1;
        w_expected = ~r_pattern;
        w_wdata    = ~r_pattern;
      end
      c_ST_M2_W: begin
        w_busy  = 1'b1;
        w_write = 1'b1;
        w_wdata = r_pattern;
      end
      c_ST_M3_R: begin
        w_busy     = 1'b1;
        w_read     = 1'b1;
        w_expected = r_pattern;
        w_wdata    = r_pattern;
      end
      c_ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  assign w_mismatch = w_read && (ram_bus.ram_data_out != w_expected);

  //--------------------------------------------------------------------------
  // Pattern latch and result registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pattern    <= '0;
      r_fail_count <= '0;
      r_fail_addr  <= '0;
      r_pass       <= 1'b0;
    end else if (w_start_accept) begin
      r_pattern    <= i_pattern;
      r_fail_count <= '0;
      r_fail_addr  <= '0;
      r_pass       <= 1'b0;
    end else begin
      if (w_mismatch) begin
        if (r_fail_count != c_CNT_MAX) begin
          r_fail_count <= r_fail_count + 1'b1;
        end
        // The count saturates above zero, so zero marks the first mismatch
        if (r_fail_count == '0) begin
          r_fail_addr <= w_addr;
        end
      end
      // Verdict includes the final read, so it is valid on entry to DONE
      if ((r_state == c_ST_M3_R) && w_last) begin
        r_pass <= (r_fail_count == '0) && !w_mismatch;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_pass       = r_pass;
  assign o_fail_count = r_fail_count;
  assign o_fail_addr  = r_fail_addr;

  assign ram_bus.ram_address  = w_addr;
  assign ram_bus.ram_data_in  = w_wdata;
  // Gated by rst_n so no write can slip through while reset is held
  assign ram_bus.ram_write_en = w_write & rst_n;

endmodule
`default_nettype wire
